// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register addresses, exception codes,
// handler vector and SR/Cause field positions.
package cp0_defs;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT = 32'h0000_2018;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_BD    = 31;

    // Pack the SR word from its live fields; unimplemented bits read as 0.
    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_LO +: 6] = im;
        w[SR_EXL]        = exl;
        w[SR_IE]         = ie;
        return w;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]            = bd;
        w[CAUSE_IP_LO +: 6]    = ip;
        w[CAUSE_EXC_LO +: 5]   = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage pipeline <-> CP0 signal bundle: mtc0/mfc0/eret controls,
// exception inputs, interrupt lines and the request/EPC/read-data returns.
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId, interrupt sampling and the single
// flush request that sends the pipeline to the exception handler.
module cp0
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VAL = PRID_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    cp0_if.slave   bus
);

    logic [5:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;

    logic        int_hit;
    logic        exc_hit;
    logic        int_req;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // EXL masks both sources so a handler cannot be re-entered.
    assign int_hit = (|(bus.HWInt & im_reg)) & ie_reg & ~exl_reg;
    assign exc_hit = (bus.ExcCode != 5'd0) & ~exl_reg;
    assign int_req = int_hit | exc_hit;

    // A faulting delay-slot instruction restarts at its branch.
    assign pc_aligned = {bus.PC[31:2], 2'b00};
    assign epc_next   = bus.BD ? (pc_aligned - 32'd4) : pc_aligned;

    assign sr_word    = pack_sr(im_reg, exl_reg, ie_reg);
    assign cause_word = pack_cause(bd_reg, ip_reg, exc_code_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            im_reg       <= '0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= '0;
            exc_code_reg <= '0;
            epc_reg      <= '0;
        end else begin
            ip_reg <= bus.HWInt;
            if (int_req) begin
                // The instruction in M is cancelled, so its mtc0/eret effects are dropped.
                exl_reg      <= 1'b1;
                exc_code_reg <= int_hit ? EXC_INT : bus.ExcCode;
                bd_reg       <= bus.BD;
                epc_reg      <= epc_next;
            end else begin
                if (bus.EXLClr) begin
                    exl_reg <= 1'b0;
                end
                if (bus.We) begin
                    case (bus.A2)
                        ADDR_SR: begin
                            im_reg  <= bus.DIn[SR_IM_LO +: 6];
                            exl_reg <= bus.DIn[SR_EXL];
                            ie_reg  <= bus.DIn[SR_IE];
                        end
                        ADDR_EPC: epc_reg <= {bus.DIn[31:2], 2'b00};
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        bus.DOut = '0;
        case (bus.A1)
            ADDR_SR:    bus.DOut = sr_word;
            ADDR_CAUSE: bus.DOut = cause_word;
            ADDR_EPC:   bus.DOut = epc_reg;
            ADDR_PRID:  bus.DOut = PRID_VAL;
            default:    bus.DOut = '0;
        endcase
    end

    assign bus.IntReq = int_req;
    assign bus.EPC    = epc_reg;

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: word-level CP0 model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_cp0;

    logic clk;
    logic reset;
    cp0_if bus();

    cp0 #(.PRID_VAL(32'h0000_2018)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: whole architectural words, updated from the register rules.
    logic [31:0] m_sr    = 32'h0;
    logic [31:0] m_cause = 32'h0;
    logic [31:0] m_epc   = 32'h0;

    function automatic logic m_int_hit();
        return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int_hit() || ((bus.ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_dout();
        case (bus.A1)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2018;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] pc_w;
        logic [31:0] new_cause;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            new_cause = (m_cause & ~32'h0000_FC00) | (32'(bus.HWInt) << 10);
            if (m_req()) begin
                pc_w      = bus.PC & 32'hFFFF_FFFC;
                m_epc     = bus.BD ? pc_w - 32'd4 : pc_w;
                new_cause = (bus.BD ? 32'h8000_0000 : 32'h0) | (32'(bus.HWInt) << 10)
                          | (m_int_hit() ? 32'h0 : (32'(bus.ExcCode) << 2));
                m_sr      = m_sr | 32'h2;
            end else begin
                if (bus.EXLClr) m_sr = m_sr & ~32'h2;
                if (bus.We && bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
                if (bus.We && bus.A2 == 5'd14) m_epc = bus.DIn & 32'hFFFF_FFFC;
            end
            m_cause = new_cause;
        end
    endtask

    // Per-cycle comparison against the model, then advance the model at the edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_intreq", {31'b0, bus.IntReq}, {31'b0, m_req()});
            check("cyc_epc", bus.EPC, m_epc);
            check("cyc_dout", bus.DOut, m_dout());
            @(posedge clk);
            model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        bus.A1 = a;
        #1;
        check(name, bus.DOut, exp);
    endtask

    task automatic req_is(input logic exp, input string name);
        #1;
        check(name, {31'b0, bus.IntReq}, {31'b0, exp});
    endtask

    initial begin
        reset = 1'b1;
        bus.A1 = 0; bus.A2 = 0; bus.DIn = 0; bus.We = 0; bus.PC = 0;
        bus.BD = 0; bus.ExcCode = 0; bus.HWInt = 0; bus.EXLClr = 0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        cyc();
        rd(5'd15, 32'h0000_2018, "prid");
        req_is(1'b0, "rst_intreq");
        rd(5'd3, 32'h0, "unmapped_read");

        // Enabled interrupt, not in a delay slot.
        bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        cyc();
        bus.We = 0; bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010; bus.BD = 0;
        req_is(1'b1, "int_req");
        cyc();
        bus.HWInt = 0;
        rd(5'd14, 32'h0000_3010, "int_epc");
        rd(5'd12, 32'h0000_0403, "int_sr");
        rd(5'd13, 32'h0000_0400, "int_cause");
        check("int_epc_port", bus.EPC, 32'h0000_3010);

        // Exception in a delay slot with interrupts disabled.
        bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0;
        cyc();
        bus.We = 0; bus.ExcCode = 5'd10; bus.PC = 32'h0000_3020; bus.BD = 1;
        req_is(1'b1, "ri_req");
        cyc();
        bus.ExcCode = 0; bus.BD = 0;
        rd(5'd14, 32'h0000_301C, "ri_epc");
        rd(5'd13, 32'h8000_0028, "ri_cause");

        // EXL=1 blocks nested requests while IP keeps tracking HWInt.
        bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
        cyc();
        bus.We = 0; bus.ExcCode = 5'd12; bus.HWInt = 6'b000001;
        req_is(1'b0, "exl_block");
        cyc();
        rd(5'd13, 32'h8000_0428, "exl_ip_track");
        bus.ExcCode = 0; bus.EXLClr = 1;
        req_is(1'b0, "eret_cycle_noreq");
        cyc();
        bus.EXLClr = 0; bus.PC = 32'h0000_3040;
        req_is(1'b1, "pending_int_after_eret");
        cyc();
        bus.HWInt = 0;
        rd(5'd14, 32'h0000_3040, "pending_epc");
        rd(5'd13, 32'h0000_0400, "pending_cause");

        // mtc0 EPC cancelled by a same-cycle request, then accepted.
        bus.EXLClr = 1;
        cyc();
        bus.EXLClr = 0; bus.ExcCode = 5'd5; bus.PC = 32'h0000_3050;
        bus.We = 1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3003;
        req_is(1'b1, "ades_req");
        cyc();
        bus.ExcCode = 0;
        rd(5'd14, 32'h0000_3050, "epc_write_dropped");
        cyc();
        bus.We = 0;
        rd(5'd14, 32'h0000_3000, "epc_write_taken");

        // eret and a new exception in the same cycle: the exception wins.
        bus.EXLClr = 1;
        cyc();
        bus.ExcCode = 5'd4; bus.PC = 32'h0000_3060;
        req_is(1'b1, "adel_req");
        cyc();
        bus.EXLClr = 0; bus.ExcCode = 0;
        rd(5'd12, 32'h0000_0403, "adel_sr");
        rd(5'd13, 32'h0000_0010, "adel_cause");
        rd(5'd14, 32'h0000_3060, "adel_epc");

        // Reset in the handler dominates a concurrent write and interrupt.
        reset = 1; bus.HWInt = 6'b111111; bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF;
        cyc();
        reset = 0; bus.HWInt = 0; bus.We = 0;
        rd(5'd12, 32'h0, "rst2_sr");
        rd(5'd13, 32'h0, "rst2_cause");
        rd(5'd14, 32'h0, "rst2_epc");
        req_is(1'b0, "rst2_intreq");
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the pipelined MIPS-C5 core: the responder side of the decode stage's `mtc0`/`mfc0`/`eret` control (`cp0WE`, `eret_flush_D`, `Data2Reg`=mfc0 path) and of the per-stage exception codes. It sits in the M stage. It holds SR, Cause, EPC and PRId, samples hardware interrupts every cycle, and raises a single interrupt/exception request that flushes the pipeline and redirects fetch to the handler. EPC is exported so NPC can resolve `eret`.

## Interface
- `PRID_VAL`, 32'h0000_2018, read-only value of PRId (reg 15)
- `clk`  in  1  pipeline clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `A1`  in  5  read address (`instr[15:11]` of `mfc0` in M)
- `A2`  in  5  write address (`instr[15:11]` of `mtc0` in M)
- `DIn`  in  32  write data (forwarded rt of `mtc0`)
- `We`  in  1  write enable (`cp0WE` pipelined to M)
- `PC`  in  32  PC of the instruction currently in M (or of the first valid stage behind a bubble)
- `BD`  in  1  instruction in M is in a branch delay slot
- `ExcCode`  in  5  exception code carried to M; 0 = none
- `HWInt`  in  6  device/timer interrupt lines, level-sensitive
- `EXLClr`  in  1  `eret` in M
- `IntReq`  out  1  take interrupt/exception this cycle
- `EPC`  out  32  current EPC register
- `DOut`  out  32  read data

## Operation
- Registers: SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC 32-bit; PRId constant. Unimplemented bits read 0.
- Reset: SR, Cause, EPC <= 0; `IntReq` = 0 (EXL=0, IE=0, `ExcCode`=0 input assumed at reset by pipeline flush).
- `IntHit` = |(`HWInt` & IM) & IE & ~EXL. `ExcHit` = (`ExcCode` != 0) & ~EXL. `IntReq` = `IntHit` | `ExcHit` (combinational).
- Priority: interrupt over exception. On `IntReq` at edge: EXL <= 1; Cause.ExcCode <= `IntHit` ? 0 : `ExcCode`; Cause.BD <= `BD`; EPC <= `BD` ? {`PC`[31:2],2'b0} − 4 : {`PC`[31:2],2'b0} (mod 2^32).
- `EXLClr` (no `IntReq`): EXL <= 0. `EXLClr` and `IntReq` same cycle: `IntReq` wins (EXL stays/becomes 1).
- `We` with no `IntReq`: A2=12 writes IM and EXL/IE from `DIn`; A2=14 writes EPC <= {`DIn`[31:2],2'b0}; A2=13, 15, others ignored. `We` with `IntReq`: write suppressed (instruction is being cancelled).
- Cause.IP <= `HWInt` every cycle, independent of all other events, including during `IntReq`.
- `DOut`: combinational mux on `A1`: 12 SR, 13 Cause, 14 EPC, 15 `PRID_VAL`, else 0. Reflects pre-edge contents.

## Timing
- Reads: zero latency, combinational.
- Writes and exception entry: visible on `DOut`/`EPC` the cycle after the edge.
- `IntReq` is combinational from `HWInt`, `ExcCode`, SR; pipeline flushes and loads PC 32'h0000_4180 at the same edge CP0 latches.
- Nested requests blocked while EXL=1; `HWInt` still updates IP.
- Reset dominates every event in the same cycle.

## Structure
- Shared package `cp0_defs`: register addresses (SR=12, CAUSE=13, EPC=14, PRID=15), ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), handler address 32'h0000_4180, SR/Cause bit positions.
- Single flat module; no sub-module.

## Test plan
- Reset, then read A1=12,13,14 -> 0; A1=15 -> 32'h0000_2018; `IntReq`=0.
- `mtc0` SR `DIn`=32'h0000_0401 (IM[10]=1, IE=1), then `HWInt`=6'b000001, `PC`=32'h0000_3010, `BD`=0 -> `IntReq`=1 same cycle; next cycle EPC=32'h0000_3010, SR=32'h0000_0403, Cause=32'h0000_0400.
- EXL=0, IE=0, `ExcCode`=10, `PC`=32'h0000_3020, `BD`=1 -> `IntReq`=1; EPC=32'h0000_301C, Cause=32'h8000_0028.
- With EXL=1, assert `ExcCode`=12 and `HWInt` -> `IntReq`=0; Cause.IP tracks `HWInt`; then `EXLClr` -> EXL=0, pending enabled `HWInt` raises `IntReq` next cycle.
- `We`=1, A2=14, `DIn`=32'h0000_3003 with `IntReq`=1 same cycle -> write dropped, EPC = exception PC; repeat without `IntReq` -> EPC=32'h0000_3000.
- `EXLClr` and `ExcCode`=4 same cycle with EXL=0 -> EXL=1, ExcCode=4; `reset` mid-handler -> all registers 0 next cycle.
